// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file
// RV32I general-purpose register file: x1..x31 storage, x0 hardwired to zero.
// Two combinational read ports with write-through bypass, one synchronous write port.
module msrv32_integer_file #(
  parameter int XLEN = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic [4:0]      rs_1_addr_in,
  input  logic [4:0]      rs_2_addr_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            wr_en_in,
  input  logic [XLEN-1:0] rd_in,
  output logic [XLEN-1:0] rs_1_out,
  output logic [XLEN-1:0] rs_2_out
);

  // Storage exists only for x1..x31; address 0 never reaches the array.
  logic [XLEN-1:0] r_regs [31:1];

  logic            w_wr_valid;
  logic            w_bypass_1;
  logic            w_bypass_2;
  logic [XLEN-1:0] w_rs_1;
  logic [XLEN-1:0] w_rs_2;

  // A write is effective only when enabled and not aimed at x0.
  assign w_wr_valid = wr_en_in && (rd_addr_in != 5'd0);

  // Bypass is suppressed while reset is held so both ports read zero.
  assign w_bypass_1 = w_wr_valid && ms_riscv32_mp_rst_n_in && (rd_addr_in == rs_1_addr_in);
  assign w_bypass_2 = w_wr_valid && ms_riscv32_mp_rst_n_in && (rd_addr_in == rs_2_addr_in);

  // Register array update: async clear, otherwise commit the write-back result.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[rd_addr_in] <= rd_in;
    end
  end

  // Read port 1: x0 reads zero, then bypass of the in-flight write, then storage.
  always_comb begin
    w_rs_1 = '0;
    if (rs_1_addr_in == 5'd0) begin
      w_rs_1 = '0;
    end else if (w_bypass_1) begin
      w_rs_1 = rd_in;
    end else begin
      w_rs_1 = r_regs[rs_1_addr_in];
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    w_rs_2 = '0;
    if (rs_2_addr_in == 5'd0) begin
      w_rs_2 = '0;
    end else if (w_bypass_2) begin
      w_rs_2 = rd_in;
    end else begin
      w_rs_2 = r_regs[rs_2_addr_in];
    end
  end

  assign rs_1_out = w_rs_1;
  assign rs_2_out = w_rs_2;

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Self-checking bench for msrv32_integer_file: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  ad;
  logic        we;
  logic [31:0] wd;
  logic [31:0] o1;
  logic [31:0] o2;

  logic [31:0] model [0:31];
  int          checks;
  int          errors;

  msrv32_integer_file #(.XLEN(32)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .rs_1_addr_in           (a1),
    .rs_2_addr_in           (a2),
    .rd_addr_in             (ad),
    .wr_en_in               (we),
    .rd_in                  (wd),
    .rs_1_out               (o1),
    .rs_2_out               (o2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural read: x0 is zero, reset forces zero, a pending write is visible.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (a == 5'd0)             return 32'd0;
    if (!rst_n)                return 32'd0;
    if (we && ad == a)         return wd;
    return model[a];
  endfunction

  task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] data,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; ad = d; wd = data; a1 = r1; a2 = r2;
  endtask

  task automatic check_ports(input string tag);
    #1;
    check_val({tag, "_rs1"}, o1, expect_rd(a1));
    check_val({tag, "_rs2"}, o2, expect_rd(a2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  // Advance one rising edge and commit the pending write into the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && ad != 5'd0) model[ad] = wd;
    #1;
  endtask

  initial begin
    logic [31:0] v;
    checks = 0;
    errors = 0;
    clear_model();

    // Reset held: writes and bypass are inert.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31);
    #2;
    check_val("reset_rs1", o1, 32'd0);
    check_val("reset_rs2", o2, 32'd0);
    tick();
    tick();
    check_val("reset_hold_rs1", o1, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    #2;
    rst_n = 1'b1;
    #1;
    check_val("post_reset_x5", o1, 32'd0);
    tick();

    // Basic write then read.
    drive(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd6);
    #1;
    check_val("basic_x7", o1, 32'h12345678);
    check_val("basic_x6", o2, 32'd0);

    // Bypass on both ports, then storage holds the new value.
    drive(1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd3, 32'hFFFF0000, 5'd3, 5'd3);
    #1;
    check_val("bypass_rs1", o1, 32'hFFFF0000);
    check_val("bypass_rs2", o2, 32'hFFFF0000);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    #1;
    check_val("bypass_stored", o1, 32'hFFFF0000);

    // x0 write is ignored and never bypassed.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check_val("x0_same_rs1", o1, 32'd0);
    check_val("x0_same_rs2", o2, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    check_val("x0_after", o1, 32'd0);

    // Fill x1..x31 with index * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      v = 32'h01010101 * i;
      drive(1'b1, i[4:0], v, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
    #1;
    check_val("fill_x31", o1, 32'h1F1F1F1F);
    check_val("fill_x17", o2, 32'h11111111);

    // Mid-operation reset for half a cycle: reads drop to zero at once.
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd31);
    #1;
    check_val("midrst_x1", o1, 32'd0);
    check_val("midrst_x31", o2, 32'd0);
    drive(1'b1, 5'd9, 32'hAAAA5555, 5'd9, 5'd9);
    #1;
    check_val("midrst_nobypass", o1, 32'd0);
    // The write enabled at this edge sees reset still asserted.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd1);
    #1;
    check_val("release_x9", o1, 32'd0);
    check_val("release_x1", o2, 32'd0);
    // First write with reset already high lands.
    drive(1'b1, 5'd2, 32'hCAFEF00D, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd9);
    #1;
    check_val("first_write_x2", o1, 32'hCAFEF00D);
    check_val("first_write_x9", o2, 32'd0);

    // Full sweep: random contents, every read pair.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, i[4:0], $urandom, 5'd0, 5'd0);
      tick();
    end
    for (int r1 = 0; r1 < 32; r1++) begin
      for (int r2 = 0; r2 < 32; r2++) begin
        drive(1'b0, 5'd0, 32'd0, r1[4:0], r2[4:0]);
        check_ports("sweep");
      end
    end

    // Randomized traffic with frequent read/write address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), d, $urandom,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      check_ports("random");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
